// File: rtl/ps2_kbd_decode.sv
// PS/2 scan-code set 2 decoder: strips E0/F0 prefixes, swallows Pause and fake shifts,
// emits one key event per complete sequence and tracks modifier / Caps Lock state.
module ps2_kbd_decode (
   input  logic       ps2_clk_i,
   input  logic       rst,
   input  logic       en,
   input  logic       rx_stb,
   input  logic [7:0] rx_data,
   input  logic       rx_err,
   input  logic       err_clr,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_brk,
   output logic       key_stb,
   output logic       key_tgl,
   output logic [7:0] sys_code,
   output logic       sys_stb,
   output logic [4:0] mods,
   output logic       err
);

   localparam logic [7:0] CODE_EXT    = 8'hE0;
   localparam logic [7:0] CODE_BRK    = 8'hF0;
   localparam logic [7:0] CODE_PAUSE  = 8'hE1;
   localparam logic [7:0] CODE_LSHIFT = 8'h12;
   localparam logic [7:0] CODE_RSHIFT = 8'h59;
   localparam logic [7:0] CODE_CTRL   = 8'h14;
   localparam logic [7:0] CODE_ALT    = 8'h11;
   localparam logic [7:0] CODE_CAPS   = 8'h58;
   localparam logic [2:0] PAUSE_LAST  = 3'd6;

   typedef enum logic [2:0] {
      IDLE,
      EXT,
      BRK,
      EXT_BRK,
      PAUSE
   } state_t;

   state_t     state_reg, state_next;
   logic [2:0] pcnt_reg, pcnt_next;

   logic       ev_emit, ev_ext, ev_brk, sys_hit, err_hit;
   logic [7:0] ev_code;
   logic       is_sys, is_prefix, is_fake;

   logic       lshift_reg, rshift_reg, lctrl_reg, rctrl_reg, lalt_reg, ralt_reg;
   logic       caps_lock_reg, caps_down_reg;

   always_comb begin
      is_sys = 1'b0;
      case (rx_data)
         8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_sys = 1'b1;
         default:                                          is_sys = 1'b0;
      endcase
      is_prefix = (rx_data == CODE_EXT) || (rx_data == CODE_BRK) || (rx_data == CODE_PAUSE);
      is_fake   = (rx_data == CODE_LSHIFT) || (rx_data == CODE_RSHIFT);
   end

   // Sequence decode for the byte currently on rx_data; only applied when it is strobed.
   always_comb begin
      state_next = state_reg;
      pcnt_next  = pcnt_reg;
      ev_emit    = 1'b0;
      ev_ext     = 1'b0;
      ev_brk     = 1'b0;
      ev_code    = rx_data;
      sys_hit    = 1'b0;
      err_hit    = 1'b0;
      if (rx_err) begin
         err_hit    = 1'b1;
         state_next = IDLE;
         pcnt_next  = 3'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (rx_data == CODE_EXT) begin
                  state_next = EXT;
               end else if (rx_data == CODE_BRK) begin
                  state_next = BRK;
               end else if (rx_data == CODE_PAUSE) begin
                  state_next = PAUSE;
                  pcnt_next  = 3'd0;
               end else if (is_sys) begin
                  sys_hit = 1'b1;
               end else begin
                  ev_emit = 1'b1;
               end
            end
            EXT: begin
               if (rx_data == CODE_BRK) begin
                  state_next = EXT_BRK;
               end else if (rx_data == CODE_EXT) begin
                  err_hit = 1'b1;
               end else if (is_fake) begin
                  state_next = IDLE;
               end else begin
                  ev_emit    = 1'b1;
                  ev_ext     = 1'b1;
                  state_next = IDLE;
               end
            end
            BRK: begin
               state_next = IDLE;
               if (is_prefix) begin
                  err_hit = 1'b1;
               end else begin
                  ev_emit = 1'b1;
                  ev_brk  = 1'b1;
               end
            end
            EXT_BRK: begin
               state_next = IDLE;
               if (is_prefix) begin
                  err_hit = 1'b1;
               end else if (!is_fake) begin
                  ev_emit = 1'b1;
                  ev_ext  = 1'b1;
                  ev_brk  = 1'b1;
               end
            end
            PAUSE: begin
               // Pause has no break code; its payload is consumed blindly.
               if (pcnt_reg == PAUSE_LAST) begin
                  ev_emit    = 1'b1;
                  ev_code    = CODE_PAUSE;
                  state_next = IDLE;
                  pcnt_next  = 3'd0;
               end else begin
                  pcnt_next = pcnt_reg + 3'd1;
               end
            end
            default: begin
               state_next = IDLE;
               pcnt_next  = 3'd0;
            end
         endcase
      end
   end

   always_ff @(posedge ps2_clk_i) begin
      if (!rst) begin
         state_reg     <= IDLE;
         pcnt_reg      <= 3'd0;
         key_code      <= 8'h00;
         key_ext       <= 1'b0;
         key_brk       <= 1'b0;
         key_stb       <= 1'b0;
         key_tgl       <= 1'b0;
         sys_code      <= 8'h00;
         sys_stb       <= 1'b0;
         err           <= 1'b0;
         lshift_reg    <= 1'b0;
         rshift_reg    <= 1'b0;
         lctrl_reg     <= 1'b0;
         rctrl_reg     <= 1'b0;
         lalt_reg      <= 1'b0;
         ralt_reg      <= 1'b0;
         caps_lock_reg <= 1'b0;
         caps_down_reg <= 1'b0;
      end else begin
         key_stb <= 1'b0;
         sys_stb <= 1'b0;
         if (en) begin
            if (err_clr) begin
               err <= 1'b0;
            end
            if (rx_stb) begin
               state_reg <= state_next;
               pcnt_reg  <= pcnt_next;
               if (err_hit) begin
                  err <= 1'b1;
               end
               if (sys_hit) begin
                  sys_code <= rx_data;
                  sys_stb  <= 1'b1;
               end
               if (ev_emit) begin
                  key_code <= ev_code;
                  key_ext  <= ev_ext;
                  key_brk  <= ev_brk;
                  key_stb  <= 1'b1;
                  key_tgl  <= ~key_tgl;
                  if (!ev_ext && ev_code == CODE_LSHIFT) lshift_reg <= ~ev_brk;
                  if (!ev_ext && ev_code == CODE_RSHIFT) rshift_reg <= ~ev_brk;
                  if (ev_code == CODE_CTRL) begin
                     if (ev_ext) rctrl_reg <= ~ev_brk;
                     else        lctrl_reg <= ~ev_brk;
                  end
                  if (ev_code == CODE_ALT) begin
                     if (ev_ext) ralt_reg <= ~ev_brk;
                     else        lalt_reg <= ~ev_brk;
                  end
                  // caps_down suppresses re-toggling on typematic repeats.
                  if (ev_code == CODE_CAPS) begin
                     if (ev_brk) begin
                        caps_down_reg <= 1'b0;
                     end else begin
                        if (!caps_down_reg) caps_lock_reg <= ~caps_lock_reg;
                        caps_down_reg <= 1'b1;
                     end
                  end
               end
            end
         end
      end
   end

   assign mods = {caps_lock_reg, lalt_reg | ralt_reg, lctrl_reg | rctrl_reg, rshift_reg, lshift_reg};

endmodule

// File: tb/tb_ps2_kbd_decode.sv
// Directed bench for ps2_kbd_decode: drives scan-code byte sequences and checks
// decoded events, response bytes, modifier state and the sticky error flag.
module tb_ps2_kbd_decode;

   logic       clk = 1'b0;
   logic       rst, en, rx_stb, rx_err, err_clr;
   logic [7:0] rx_data;
   logic [7:0] key_code, sys_code;
   logic       key_ext, key_brk, key_stb, key_tgl, sys_stb, err;
   logic [4:0] mods;

   int tests = 0;
   int fails = 0;
   int key_cnt = 0;
   int sys_cnt = 0;

   always #5 clk = ~clk;

   ps2_kbd_decode dut (
      .ps2_clk_i (clk),
      .rst       (rst),
      .en        (en),
      .rx_stb    (rx_stb),
      .rx_data   (rx_data),
      .rx_err    (rx_err),
      .err_clr   (err_clr),
      .key_code  (key_code),
      .key_ext   (key_ext),
      .key_brk   (key_brk),
      .key_stb   (key_stb),
      .key_tgl   (key_tgl),
      .sys_code  (sys_code),
      .sys_stb   (sys_stb),
      .mods      (mods),
      .err       (err)
   );

   // Strobes are high for a full cycle, so each pulse is seen at exactly one negedge.
   always @(negedge clk) begin
      if (key_stb) key_cnt <= key_cnt + 1;
      if (sys_stb) sys_cnt <= sys_cnt + 1;
   end

   task automatic send(input logic [7:0] d, input logic e);
      @(negedge clk);
      rx_stb  = 1'b1;
      rx_data = d;
      rx_err  = e;
      @(negedge clk);
      rx_stb  = 1'b0;
      rx_err  = 1'b0;
      #1;
      $display("[TB] byte %02h err=%0b -> code=%02h ext=%0b brk=%0b stb=%0b tgl=%0b sys=%02h/%0b mods=%05b err=%0b",
               d, e, key_code, key_ext, key_brk, key_stb, key_tgl, sys_code, sys_stb, mods, err);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0; en = 1'b1; rx_stb = 1'b1; rx_data = 8'h1C; rx_err = 1'b1; err_clr = 1'b0;
      @(negedge clk);
      rx_stb = 1'b0; rx_err = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if ({key_code, key_ext, key_brk, key_stb, key_tgl} !== 12'h000) begin
         fails++; $display("FAIL reset_key: got %03h want 000", {key_code, key_ext, key_brk, key_stb, key_tgl});
      end
      tests++;
      if ({sys_code, sys_stb, mods, err} !== 15'h0) begin
         fails++; $display("FAIL reset_misc: got %04h want 0000", {sys_code, sys_stb, mods, err});
      end
   endtask

   task automatic test_make_break();
      send(8'h1C, 1'b0);
      tests++;
      if ({key_code, key_ext, key_brk, key_stb, key_tgl} !== {8'h1C, 4'b0011}) begin
         fails++; $display("FAIL make_1c: got %02h %04b want 1c 0011", key_code, {key_ext, key_brk, key_stb, key_tgl});
      end
      send(8'hF0, 1'b0);
      tests++;
      if (key_stb !== 1'b0) begin
         fails++; $display("FAIL prefix_no_evt: key_stb %0b want 0", key_stb);
      end
      send(8'h1C, 1'b0);
      tests++;
      if ({key_code, key_ext, key_brk, key_stb, key_tgl, mods} !== {8'h1C, 4'b0110, 5'b0}) begin
         fails++; $display("FAIL break_1c: got %02h %04b %05b want 1c 0110 00000", key_code,
                           {key_ext, key_brk, key_stb, key_tgl}, mods);
      end
   endtask

   task automatic test_ext();
      int c0;
      c0 = key_cnt;
      send(8'hE0, 1'b0);
      send(8'h75, 1'b0);
      tests++;
      if ({key_code, key_ext, key_brk} !== {8'h75, 2'b10}) begin
         fails++; $display("FAIL ext_make: got %02h %0b%0b want 75 10", key_code, key_ext, key_brk);
      end
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h75, 1'b0);
      tests++;
      if ({key_code, key_ext, key_brk} !== {8'h75, 2'b11}) begin
         fails++; $display("FAIL ext_break: got %02h %0b%0b want 75 11", key_code, key_ext, key_brk);
      end
      tests++;
      if (key_cnt - c0 !== 2) begin
         fails++; $display("FAIL ext_count: got %0d want 2", key_cnt - c0);
      end
   endtask

   task automatic test_mods();
      logic [7:0] seq [12];
      logic [4:0] exp [12];
      int c0;
      seq = '{8'h12, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h58, 8'hF0, 8'h12, 8'h14, 8'hE0, 8'h11, 8'hF0};
      exp = '{5'b00001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b00001,
              5'b00001, 5'b00000, 5'b00100, 5'b00100, 5'b01100, 5'b01100};
      for (int i = 0; i < 12; i++) begin
         send(seq[i], 1'b0);
         tests++;
         if (mods !== exp[i]) begin
            fails++; $display("FAIL mods_step%0d: got %05b want %05b", i, mods, exp[i]);
         end
      end
      send(8'h14, 1'b0);
      tests++;
      if (mods !== 5'b01000) begin
         fails++; $display("FAIL lctrl_break: got %05b want 01000", mods);
      end
      c0 = key_cnt;
      send(8'hE0, 1'b0);
      send(8'h12, 1'b0);
      tests++;
      if (key_cnt !== c0 || mods !== 5'b01000) begin
         fails++; $display("FAIL fake_shift: cnt+%0d mods %05b want +0 01000", key_cnt - c0, mods);
      end
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h11, 1'b0);
      send(8'hF0, 1'b0);
      send(8'h58, 1'b0);
      tests++;
      if (mods !== 5'b00000) begin
         fails++; $display("FAIL mods_clear: got %05b want 00000", mods);
      end
   endtask

   task automatic test_pause();
      logic [7:0] seq [8];
      int c0;
      seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      c0 = key_cnt;
      for (int i = 0; i < 7; i++) send(seq[i], 1'b0);
      tests++;
      if (key_cnt !== c0) begin
         fails++; $display("FAIL pause_early: got %0d events want 0", key_cnt - c0);
      end
      send(seq[7], 1'b0);
      tests++;
      if ({key_code, key_ext, key_brk, key_stb, mods} !== {8'hE1, 3'b001, 5'b0} || key_cnt - c0 !== 1) begin
         fails++; $display("FAIL pause_evt: got %02h %03b %05b n=%0d want e1 001 00000 n=1", key_code,
                           {key_ext, key_brk, key_stb}, mods, key_cnt - c0);
      end
   endtask

   task automatic test_err();
      int c0;
      c0 = key_cnt;
      send(8'hF0, 1'b0);
      send(8'hF0, 1'b0);
      tests++;
      if (err !== 1'b1 || key_cnt !== c0) begin
         fails++; $display("FAIL brk_brk: err %0b n=%0d want 1 n=0", err, key_cnt - c0);
      end
      send(8'h1C, 1'b0);
      tests++;
      if ({key_code, key_ext, key_brk, key_stb} !== {8'h1C, 3'b001}) begin
         fails++; $display("FAIL after_err: got %02h %03b want 1c 001", key_code, {key_ext, key_brk, key_stb});
      end
      pulse_clr();
      tests++;
      if (err !== 1'b0) begin
         fails++; $display("FAIL err_clr: got %0b want 0", err);
      end
      @(negedge clk);
      rx_stb = 1'b1; rx_err = 1'b1; rx_data = 8'h00; err_clr = 1'b1;
      @(negedge clk);
      rx_stb = 1'b0; rx_err = 1'b0; err_clr = 1'b0;
      #1;
      tests++;
      if (err !== 1'b1) begin
         fails++; $display("FAIL set_wins: got %0b want 1", err);
      end
   endtask

   task automatic test_sys();
      int k0, s0;
      pulse_clr();
      k0 = key_cnt; s0 = sys_cnt;
      send(8'hAA, 1'b0);
      tests++;
      if ({sys_code, sys_stb, key_stb} !== {8'hAA, 2'b10} || key_cnt !== k0 || sys_cnt - s0 !== 1) begin
         fails++; $display("FAIL sys_aa: got %02h %0b%0b k+%0d s+%0d want aa 10 k+0 s+1", sys_code, sys_stb,
                           key_stb, key_cnt - k0, sys_cnt - s0);
      end
      send(8'hE0, 1'b1);
      tests++;
      if (err !== 1'b1) begin
         fails++; $display("FAIL rx_err: got %0b want 1", err);
      end
      send(8'h75, 1'b0);
      tests++;
      if ({key_code, key_ext, key_brk, key_stb} !== {8'h75, 3'b001}) begin
         fails++; $display("FAIL err_idle: got %02h %03b want 75 001", key_code, {key_ext, key_brk, key_stb});
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      c0 = key_cnt;
      @(negedge clk);
      rx_stb = 1'b1; rx_data = 8'hF0;
      @(negedge clk);
      rx_data = 8'h2A;
      @(negedge clk);
      #1;
      tests++;
      if ({key_code, key_brk, key_stb} !== {8'h2A, 2'b11}) begin
         fails++; $display("FAIL b2b_break: got %02h %0b%0b want 2a 11", key_code, key_brk, key_stb);
      end
      @(negedge clk);
      rx_stb = 1'b0;
      #1;
      tests++;
      if ({key_code, key_brk, key_stb} !== {8'h2A, 2'b01} || key_cnt - c0 !== 2) begin
         fails++; $display("FAIL b2b_make: got %02h %0b%0b n=%0d want 2a 01 n=2", key_code, key_brk, key_stb,
                           key_cnt - c0);
      end
      @(negedge clk);
      #1;
      tests++;
      if (key_stb !== 1'b0) begin
         fails++; $display("FAIL stb_width: got %0b want 0", key_stb);
      end
   endtask

   task automatic test_enable();
      logic tgl0;
      int c0;
      send(8'h33, 1'b0);
      tgl0 = key_tgl;
      c0 = key_cnt;
      @(negedge clk);
      en = 1'b0; rx_stb = 1'b1; rx_data = 8'h44;
      @(negedge clk);
      #1;
      tests++;
      if ({key_code, key_stb, key_tgl} !== {8'h33, 1'b0, tgl0} || key_cnt !== c0) begin
         fails++; $display("FAIL en_freeze: got %02h %0b%0b n=%0d want 33 0%0b n=0", key_code, key_stb,
                           key_tgl, key_cnt - c0, tgl0);
      end
      rx_stb = 1'b0; en = 1'b1;
   endtask

   task automatic test_reset_mid();
      send(8'h12, 1'b0);
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests++;
      if (mods !== 5'b0 || key_code !== 8'h00) begin
         fails++; $display("FAIL mid_reset: mods %05b code %02h want 00000 00", mods, key_code);
      end
      send(8'h75, 1'b0);
      tests++;
      if ({key_code, key_ext, key_brk, key_stb, key_tgl} !== {8'h75, 4'b0011}) begin
         fails++; $display("FAIL mid_next: got %02h %04b want 75 0011", key_code, {key_ext, key_brk, key_stb, key_tgl});
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b1; rx_stb = 1'b0; rx_err = 1'b0; rx_data = 8'h00; err_clr = 1'b0;
      test_reset();
      test_make_break();
      test_ext();
      test_mods();
      test_pause();
      test_err();
      test_sys();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
